hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core with data cache.
- Detects load-use hazards and inserts one bubble; flushes IF/ID and ID/EX on a taken branch resolved in EX.
- Freezes the whole pipeline during a D-cache miss and runs the miss request/refill handshake to memory.
- Sits beside the forwarding unit; together they resolve all data hazards. Also keeps saturating stall/miss performance counters.

Parameters:
- TIMEOUT_W, 8, width of the miss watchdog counter; error if memory stays silent for 2^TIMEOUT_W-1 cycles.
- PERF_W, 16, width of the saturating performance counters.

Ports:
- clk  input  1  pipeline clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- ID_Rs  input  5  rs field of instruction in ID
- ID_Rt  input  5  rt field of instruction in ID
- ID_UseRt  input  1  ID instruction reads rt as a source
- EX_MemRead  input  1  instruction in EX is a load
- EX_WR_out  input  5  destination register of instruction in EX
- EX_BranchTaken  input  1  branch in EX resolved taken
- M_MemRead  input  1  load in M stage
- M_MemWrite  input  1  store in M stage
- dcache_hit  input  1  D-cache hit for the current M-stage access
- mem_ready  input  1  memory line available (one-cycle pulse)
- PCWrite  output  1  PC update enable
- IF_ID_Write  output  1  IF/ID register enable
- IF_ID_Flush  output  1  clear IF/ID to NOP
- ID_EX_Flush  output  1  clear ID/EX control bits (bubble)
- pipe_freeze  output  1  hold ID/EX, EX/M, M/WB registers
- mem_req  output  1  line-fill request to memory
- refill_we  output  1  D-cache line write enable
- miss_err  output  1  sticky watchdog error
- stall_cnt  output  PERF_W  cycles with pipe_freeze or load-use stall
- miss_cnt  output  PERF_W  D-cache misses taken

Behaviour:
- States: RUN, MISS_WAIT, REFILL. Reset state is RUN.
- Reset values: mem_req=0, refill_we=0, miss_err=0, counters=0. Combinational outputs decode from state RUN.
- miss = (M_MemRead|M_MemWrite) & ~dcache_hit.
- loaduse = EX_MemRead & (EX_WR_out!=0) & ((EX_WR_out==ID_Rs) | (ID_UseRt & EX_WR_out==ID_Rt)).
- RUN, miss=1:
  - pipe_freeze=1, PCWrite=0, IF_ID_Write=0, all flushes 0.
  - Next state MISS_WAIT; miss_cnt+1.
- RUN, miss=0, priority branch > load-use:
  - EX_BranchTaken: IF_ID_Flush=1, ID_EX_Flush=1, PCWrite=1, IF_ID_Write=1. A simultaneous load-use is ignored because the ID instruction is discarded.
  - Else loaduse: PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1. Exactly one bubble per hazard, since the load advances to M next cycle.
  - Else: PCWrite=1, IF_ID_Write=1, all else 0.
- MISS_WAIT:
  - pipe_freeze=1, mem_req=1 (registered, asserted from the first MISS_WAIT cycle), PCWrite=0, IF_ID_Write=0, flushes 0.
  - On mem_ready: go to REFILL, mem_req drops the next cycle.
  - Watchdog counts MISS_WAIT cycles. At all-ones, miss_err=1 (sticky until reset); FSM stays in MISS_WAIT.
- REFILL:
  - One cycle: refill_we=1, pipe_freeze=1, then RUN.
  - In RUN the M access re-probes and hits.
  - Watchdog clears on leaving MISS_WAIT.
- EX_BranchTaken and loaduse are ignored while not in RUN. The frozen EX instruction is re-evaluated on return to RUN.
- mem_ready outside MISS_WAIT is ignored.
- stall_cnt increments every cycle pipe_freeze=1 or a load-use bubble is inserted. Both counters saturate at all-ones, no wrap.
- rst low mid-miss: immediately returns to RUN, mem_req=0, refill_we=0. The pending request is abandoned and memory must tolerate the dropped request.

Test Plan:
- lw $2 in EX (EX_MemRead=1, EX_WR_out=2), add $3,$2,$4 in ID (ID_Rs=2) -> one cycle of PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1; stall_cnt=1.
- EX_WR_out=0 with EX_MemRead=1, ID_Rs=0 -> no stall. EX_WR_out=5, ID_Rt=5, ID_UseRt=0 -> no stall.
- EX_BranchTaken=1 together with a load-use condition -> IF_ID_Flush=1, ID_EX_Flush=1, PCWrite=1 for one cycle, no stall.
- M_MemRead=1, dcache_hit=0, mem_ready after 10 cycles:
  - pipe_freeze high for 12 cycles (1 RUN + 10 MISS_WAIT + 1 REFILL).
  - mem_req high for 10 cycles; refill_we pulses once.
  - miss_cnt=1, stall_cnt=12.
- Miss with mem_ready never asserted, TIMEOUT_W=4 -> miss_err=1 after 15 MISS_WAIT cycles; it stays high until rst low, then mem_req=0 and state RUN.
- PERF_W=4 with 20 consecutive load-use stalls -> stall_cnt holds at 15.

Source files
------------

// File: rtl/hazard_stall_ctrl_if.sv
// rtl/hazard_stall_ctrl_if.sv - memory line-fill handshake between the stall controller and memory
//
// Signals:
//   mem_req    controller -> memory  line-fill request, high for the whole wait
//   mem_ready  memory -> controller  line available, one-cycle pulse
//   refill_we  controller -> D-cache line write enable, one-cycle pulse
interface hazard_stall_ctrl_if;
    logic mem_req;
    logic mem_ready;
    logic refill_we;

    modport master (
        output mem_req,
        output refill_we,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  refill_we,
        output mem_ready
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - load-use / branch / D-cache miss pipeline sequencing controller
//
// Parameters:
//   TIMEOUT_W  width of the miss watchdog; miss_err after 2^TIMEOUT_W-1 silent wait cycles
//   PERF_W     width of the saturating stall/miss counters
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-low reset
//   ID_Rs, ID_Rt, ID_UseRt   source operands of the instruction in ID
//   EX_MemRead, EX_WR_out    load flag and destination of the instruction in EX
//   EX_BranchTaken       branch in EX resolved taken
//   M_MemRead, M_MemWrite, dcache_hit   M-stage access and its D-cache lookup result
//   mem                  line-fill handshake (mem_req, mem_ready, refill_we)
//   PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, pipe_freeze   pipeline controls
//   miss_err             sticky watchdog error
//   stall_cnt, miss_cnt  saturating performance counters
module hazard_stall_ctrl #(
    parameter int TIMEOUT_W = 8,
    parameter int PERF_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        ID_Rs,
    input  logic [4:0]        ID_Rt,
    input  logic              ID_UseRt,
    input  logic              EX_MemRead,
    input  logic [4:0]        EX_WR_out,
    input  logic              EX_BranchTaken,
    input  logic              M_MemRead,
    input  logic              M_MemWrite,
    input  logic              dcache_hit,
    hazard_stall_ctrl_if.master mem,
    output logic              PCWrite,
    output logic              IF_ID_Write,
    output logic              IF_ID_Flush,
    output logic              ID_EX_Flush,
    output logic              pipe_freeze,
    output logic              miss_err,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] miss_cnt
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MISS_WAIT = 2'd1,
        REFILL    = 2'd2
    } state_t;

    localparam logic [TIMEOUT_W-1:0] WD_MAX   = {TIMEOUT_W{1'b1}};
    localparam logic [PERF_W-1:0]    PERF_MAX = {PERF_W{1'b1}};

    state_t               state;
    logic [TIMEOUT_W-1:0] wd;
    logic                 miss;
    logic                 loaduse;
    logic                 bubble;

    assign miss = (M_MemRead | M_MemWrite) & ~dcache_hit;

    // Register 0 is hard-wired zero, so a load targeting it never creates a hazard.
    assign loaduse = EX_MemRead & (EX_WR_out != 5'd0) &
                     ((EX_WR_out == ID_Rs) | (ID_UseRt & (EX_WR_out == ID_Rt)));

    // Pipeline controls decode from the state; hazards are only acted upon in RUN,
    // and a miss outranks both the branch flush and the load-use bubble.
    always_comb begin
        PCWrite     = 1'b1;
        IF_ID_Write = 1'b1;
        IF_ID_Flush = 1'b0;
        ID_EX_Flush = 1'b0;
        pipe_freeze = 1'b0;
        bubble      = 1'b0;
        case (state)
            RUN: begin
                if (miss) begin
                    PCWrite     = 1'b0;
                    IF_ID_Write = 1'b0;
                    pipe_freeze = 1'b1;
                end else if (EX_BranchTaken) begin
                    // The ID instruction is discarded, so any load-use on it is moot.
                    IF_ID_Flush = 1'b1;
                    ID_EX_Flush = 1'b1;
                end else if (loaduse) begin
                    PCWrite     = 1'b0;
                    IF_ID_Write = 1'b0;
                    ID_EX_Flush = 1'b1;
                    bubble      = 1'b1;
                end
            end
            default: begin
                PCWrite     = 1'b0;
                IF_ID_Write = 1'b0;
                pipe_freeze = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= RUN;
            mem.mem_req   <= 1'b0;
            mem.refill_we <= 1'b0;
            miss_err      <= 1'b0;
            wd            <= '0;
            stall_cnt     <= '0;
            miss_cnt      <= '0;
        end else begin
            if ((pipe_freeze | bubble) && (stall_cnt != PERF_MAX)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end

            case (state)
                RUN: begin
                    if (miss) begin
                        state       <= MISS_WAIT;
                        mem.mem_req <= 1'b1;
                        wd          <= '0;
                        if (miss_cnt != PERF_MAX) begin
                            miss_cnt <= miss_cnt + 1'b1;
                        end
                    end
                end
                MISS_WAIT: begin
                    if (mem.mem_ready) begin
                        state         <= REFILL;
                        mem.mem_req   <= 1'b0;
                        mem.refill_we <= 1'b1;
                        wd            <= '0;
                    end else begin
                        // Watchdog saturates; the error is raised as it reaches all-ones
                        // but the request stays outstanding in case memory answers late.
                        if (wd != WD_MAX) begin
                            wd <= wd + 1'b1;
                        end
                        if (wd == WD_MAX - 1'b1) begin
                            miss_err <= 1'b1;
                        end
                    end
                end
                REFILL: begin
                    // After the line write the M access re-probes in RUN and hits.
                    state         <= RUN;
                    mem.refill_we <= 1'b0;
                end
                default: begin
                    state         <= RUN;
                    mem.mem_req   <= 1'b0;
                    mem.refill_we <= 1'b0;
                    wd            <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - testbench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ID_Rs, ID_Rt, EX_WR_out;
    logic        ID_UseRt, EX_MemRead, EX_BranchTaken;
    logic        M_MemRead, M_MemWrite, dcache_hit, mem_ready;

    logic        PCWrite_a, IF_ID_Write_a, IF_ID_Flush_a, ID_EX_Flush_a, pipe_freeze_a, miss_err_a;
    logic        PCWrite_b, IF_ID_Write_b, IF_ID_Flush_b, ID_EX_Flush_b, pipe_freeze_b, miss_err_b;
    logic [15:0] stall_a, miss_a;
    logic [3:0]  stall_b, miss_b;
    logic [6:0]  ctl_a, ctl_b;

    int vectors = 0;
    int miscompares = 0;

    hazard_stall_ctrl_if ifa ();
    hazard_stall_ctrl_if ifb ();
    assign ifa.mem_ready = mem_ready;
    assign ifb.mem_ready = mem_ready;

    hazard_stall_ctrl #(.TIMEOUT_W(8), .PERF_W(16)) dut_a (
        .clk(clk), .rst(rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UseRt(ID_UseRt),
        .EX_MemRead(EX_MemRead), .EX_WR_out(EX_WR_out), .EX_BranchTaken(EX_BranchTaken),
        .M_MemRead(M_MemRead), .M_MemWrite(M_MemWrite), .dcache_hit(dcache_hit),
        .mem(ifa.master), .PCWrite(PCWrite_a), .IF_ID_Write(IF_ID_Write_a),
        .IF_ID_Flush(IF_ID_Flush_a), .ID_EX_Flush(ID_EX_Flush_a), .pipe_freeze(pipe_freeze_a),
        .miss_err(miss_err_a), .stall_cnt(stall_a), .miss_cnt(miss_a)
    );

    hazard_stall_ctrl #(.TIMEOUT_W(4), .PERF_W(4)) dut_b (
        .clk(clk), .rst(rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UseRt(ID_UseRt),
        .EX_MemRead(EX_MemRead), .EX_WR_out(EX_WR_out), .EX_BranchTaken(EX_BranchTaken),
        .M_MemRead(M_MemRead), .M_MemWrite(M_MemWrite), .dcache_hit(dcache_hit),
        .mem(ifb.master), .PCWrite(PCWrite_b), .IF_ID_Write(IF_ID_Write_b),
        .IF_ID_Flush(IF_ID_Flush_b), .ID_EX_Flush(ID_EX_Flush_b), .pipe_freeze(pipe_freeze_b),
        .miss_err(miss_err_b), .stall_cnt(stall_b), .miss_cnt(miss_b)
    );

    // {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, pipe_freeze, mem_req, refill_we}
    assign ctl_a = {PCWrite_a, IF_ID_Write_a, IF_ID_Flush_a, ID_EX_Flush_a, pipe_freeze_a,
                    ifa.mem_req, ifa.refill_we};
    assign ctl_b = {PCWrite_b, IF_ID_Write_b, IF_ID_Flush_b, ID_EX_Flush_b, pipe_freeze_b,
                    ifb.mem_req, ifb.refill_we};

    initial forever #5 clk = ~clk;

    // Reference model: an outstanding memory transaction, a line being written,
    // how long memory has been silent, and unbounded event tallies.
    bit         m_busy, m_fill, m_err_a, m_err_b;
    int         m_wait, m_stall, m_miss;
    bit         e_count, e_newmiss;
    logic [6:0] e_ctl;

    function automatic int sat(input int v, input int w);
        int lim;
        lim = (1 << w) - 1;
        return (v > lim) ? lim : v;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_fill = 0; m_err_a = 0; m_err_b = 0;
        m_wait = 0; m_stall = 0; m_miss = 0;
    endtask

    task automatic model_eval();
        bit in_run, acc_miss, lu, freeze, br_go, bub;
        in_run   = !m_busy && !m_fill;
        acc_miss = (M_MemRead || M_MemWrite) && !dcache_hit;
        lu       = EX_MemRead && (EX_WR_out != 0) &&
                   ((EX_WR_out == ID_Rs) || (ID_UseRt && (EX_WR_out == ID_Rt)));
        freeze   = !in_run || acc_miss;
        br_go    = !freeze && EX_BranchTaken;
        bub      = !freeze && !EX_BranchTaken && lu;
        e_ctl    = {!freeze && !bub, !freeze && !bub, br_go, br_go || bub, freeze, m_busy, m_fill};
        e_count  = freeze || bub;
        e_newmiss = in_run && acc_miss;
    endtask

    task automatic model_step();
        if (e_count) m_stall++;
        if (e_newmiss) begin
            m_miss++;
            m_busy = 1;
            m_wait = 0;
        end else if (m_busy) begin
            if (mem_ready) begin
                m_busy = 0;
                m_fill = 1;
            end else begin
                m_wait++;
                if (m_wait >= 15)  m_err_b = 1;
                if (m_wait >= 255) m_err_a = 1;
            end
        end else if (m_fill) begin
            m_fill = 0;
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic use_rt,
                         input logic exm, input logic [4:0] wr, input logic br,
                         input logic mr, input logic mw, input logic hit, input logic rdy);
        ID_Rs = rs; ID_Rt = rt; ID_UseRt = use_rt; EX_MemRead = exm; EX_WR_out = wr;
        EX_BranchTaken = br; M_MemRead = mr; M_MemWrite = mw; dcache_hit = hit; mem_ready = rdy;
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (2) @(posedge clk);
        model_reset();
        model_eval();
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        #1;
        vectors++;
        if (ctl_a !== 7'b1100000 || ctl_b !== 7'b1100000) begin
            miscompares++;
            $display("FAIL reset_ctl a=%b b=%b expected 1100000", ctl_a, ctl_b);
        end
        vectors++;
        if ({miss_err_a, miss_err_b, stall_a, miss_a, stall_b, miss_b} !== '0) begin
            miscompares++;
            $display("FAIL reset_regs err=%b%b stall=%0d/%0d miss=%0d/%0d expected all 0",
                     miss_err_a, miss_err_b, stall_a, stall_b, miss_a, miss_b);
        end
        do_reset();
    endtask

    task automatic test_loaduse();
        do_reset();
        drive(2, 4, 1, 1, 2, 0, 0, 0, 1, 0);
        @(negedge clk);
        vectors++;
        if (ctl_a !== 7'b0001000 || ctl_b !== 7'b0001000) begin
            miscompares++;
            $display("FAIL loaduse_bubble a=%b b=%b expected 0001000", ctl_a, ctl_b);
        end
        tick();
        drive(3, 2, 1, 0, 3, 0, 1, 0, 1, 0);
        @(negedge clk);
        vectors++;
        if (ctl_a !== 7'b1100000 || stall_a !== 16'd1 || stall_b !== 4'd1) begin
            miscompares++;
            $display("FAIL loaduse_once ctl=%b stall=%0d/%0d expected 1100000 stall=1",
                     ctl_a, stall_a, stall_b);
        end
        tick();
    endtask

    task automatic test_no_stall();
        do_reset();
        drive(0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        vectors++;
        if (ctl_a !== 7'b1100000) begin
            miscompares++;
            $display("FAIL nostall_r0 ctl=%b expected 1100000", ctl_a);
        end
        tick();
        drive(1, 5, 0, 1, 5, 0, 0, 0, 1, 0);
        @(negedge clk);
        vectors++;
        if (ctl_a !== 7'b1100000) begin
            miscompares++;
            $display("FAIL nostall_rt_unused ctl=%b expected 1100000", ctl_a);
        end
        tick();
        drive(1, 5, 1, 1, 5, 0, 0, 0, 1, 0);
        @(negedge clk);
        vectors++;
        if (ctl_b !== 7'b0001000) begin
            miscompares++;
            $display("FAIL stall_rt_used ctl=%b expected 0001000", ctl_b);
        end
        tick();
    endtask

    task automatic test_branch_priority();
        do_reset();
        drive(2, 0, 0, 1, 2, 1, 0, 0, 1, 0);
        @(negedge clk);
        vectors++;
        if (ctl_a !== 7'b1111000 || ctl_b !== 7'b1111000) begin
            miscompares++;
            $display("FAIL branch_flush a=%b b=%b expected 1111000", ctl_a, ctl_b);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        vectors++;
        if (stall_a !== 16'd0) begin
            miscompares++;
            $display("FAIL branch_nostall stall=%0d expected 0", stall_a);
        end
        tick();
    endtask

    task automatic test_miss_refill();
        int n_freeze, n_req, n_we;
        n_freeze = 0; n_req = 0; n_we = 0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            // miss probe, 10 silent-then-ready wait cycles, refill, then hits
            drive(2, 0, 0, 1, 2, 1, 1, 0, (i >= 12), (i == 10));
            @(negedge clk);
            n_freeze += pipe_freeze_a;
            n_req    += ifa.mem_req;
            n_we     += ifa.refill_we;
            vectors++;
            if (ctl_a !== e_ctl || ctl_b !== e_ctl) begin
                miscompares++;
                $display("FAIL miss_ctl cyc=%0d a=%b b=%b expected %b", i, ctl_a, ctl_b, e_ctl);
            end
            tick();
        end
        vectors++;
        if (n_freeze != 12 || n_req != 10 || n_we != 1) begin
            miscompares++;
            $display("FAIL miss_durations freeze=%0d req=%0d we=%0d expected 12/10/1",
                     n_freeze, n_req, n_we);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        vectors++;
        if (miss_a !== 16'd1 || stall_a !== 16'd12 || stall_b !== 4'd12) begin
            miscompares++;
            $display("FAIL miss_counts miss=%0d stall=%0d/%0d expected 1 12/12",
                     miss_a, stall_a, stall_b);
        end
        tick();
    endtask

    task automatic test_watchdog();
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        for (int k = 1; k <= 300; k++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
            @(negedge clk);
            vectors++;
            if (miss_err_b !== (k > 15) || miss_err_a !== (k > 255) || ctl_a !== 7'b0000110) begin
                miscompares++;
                $display("FAIL watchdog k=%0d err=%b/%b ctl=%b expected %b/%b 0000110",
                         k, miss_err_a, miss_err_b, ctl_a, (k > 255), (k > 15));
            end
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if (ctl_a !== 7'b1100000 || ctl_b !== 7'b1100000 || miss_err_a !== 1'b0 || miss_err_b !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_miss a=%b b=%b err=%b%b expected 1100000 err=00",
                     ctl_a, ctl_b, miss_err_a, miss_err_b);
        end
        model_reset();
        model_eval();
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(7, 0, 0, 1, 7, 0, 0, 0, 1, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        vectors++;
        if (stall_b !== 4'd15 || stall_a !== 16'd20) begin
            miscompares++;
            $display("FAIL stall_saturate stall=%0d/%0d expected 20/15", stall_a, stall_b);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(4, 0, 0, 1, 4, 0, 0, 0, 1, 0);
        @(negedge clk);
        vectors++;
        if (ctl_a !== 7'b0001000) begin
            miscompares++;
            $display("FAIL b2b_bubble ctl=%b expected 0001000", ctl_a);
        end
        tick();
        drive(4, 0, 0, 1, 4, 1, 1, 0, 0, 0);
        @(negedge clk);
        vectors++;
        if (ctl_a !== 7'b0000100) begin
            miscompares++;
            $display("FAIL b2b_miss_priority ctl=%b expected 0000100", ctl_a);
        end
        tick();
        drive(4, 0, 0, 1, 4, 1, 0, 0, 1, 1);
        tick();
        drive(4, 0, 0, 1, 4, 1, 0, 0, 1, 0);
        @(negedge clk);
        vectors++;
        if (ctl_a !== 7'b0000101) begin
            miscompares++;
            $display("FAIL b2b_refill ctl=%b expected 0000101", ctl_a);
        end
        tick();
        @(negedge clk);
        vectors++;
        if (ctl_a !== 7'b1111000) begin
            miscompares++;
            $display("FAIL b2b_reeval_branch ctl=%b expected 1111000", ctl_a);
        end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                  1'($urandom), 5'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 11) == 0),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0));
            @(negedge clk);
            vectors++;
            if (ctl_a !== e_ctl || ctl_b !== e_ctl) begin
                miscompares++;
                $display("FAIL rand_ctl i=%0d a=%b b=%b expected %b", i, ctl_a, ctl_b, e_ctl);
            end
            vectors++;
            if (miss_err_a !== m_err_a || miss_err_b !== m_err_b) begin
                miscompares++;
                $display("FAIL rand_err i=%0d err=%b/%b expected %b/%b",
                         i, miss_err_a, miss_err_b, m_err_a, m_err_b);
            end
            vectors++;
            if (stall_a !== 16'(sat(m_stall, 16)) || stall_b !== 4'(sat(m_stall, 4)) ||
                miss_a !== 16'(sat(m_miss, 16)) || miss_b !== 4'(sat(m_miss, 4))) begin
                miscompares++;
                $display("FAIL rand_cnt i=%0d stall=%0d/%0d miss=%0d/%0d expected %0d/%0d %0d/%0d",
                         i, stall_a, stall_b, miss_a, miss_b, sat(m_stall, 16), sat(m_stall, 4),
                         sat(m_miss, 16), sat(m_miss, 4));
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_loaduse();
        test_no_stall();
        test_branch_priority();
        test_miss_refill();
        test_watchdog();
        test_saturation();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
